// File: rtl/shiftreg_seq_ctrl_pkg.sv
// Shared constants for the LED shift-register sequencer: default sizes, FSM encoding, width helper.
package shiftreg_seq_ctrl_pkg;

    localparam int unsigned NB_LEDS_DEF     = 4;
    localparam int unsigned NB_PRESCALE_DEF = 24;
    localparam int unsigned NB_STEPS_DEF    = 8;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_INIT = 2'd0;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd1;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd2;

    // Bits needed to index n items; never less than one so a 1-LED build still has a position port.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/shiftreg_seq_ctrl_if.sv
// Control/status bundle between a host (master) and the sequencer (slave).
interface shiftreg_seq_ctrl_if
    import shiftreg_seq_ctrl_pkg::*;
#(
    parameter int unsigned NB_LEDS     = NB_LEDS_DEF,
    parameter int unsigned NB_PRESCALE = NB_PRESCALE_DEF,
    parameter int unsigned NB_STEPS    = NB_STEPS_DEF
);
    localparam int unsigned NB_POS = clog2(NB_LEDS);

    logic [NB_PRESCALE-1:0] i_period;
    logic [NB_STEPS-1:0]    i_burst;
    logic                   i_start;
    logic                   i_stop;
    logic                   i_step;
    logic                   i_resync;
    logic                   o_valid;
    logic                   o_sr_reset;
    logic                   o_busy;
    logic                   o_done;
    logic [NB_STEPS-1:0]    o_step_cnt;
    logic [NB_POS-1:0]      o_pos;

    modport master (
        output i_period, i_burst, i_start, i_stop, i_step, i_resync,
        input  o_valid, o_sr_reset, o_busy, o_done, o_step_cnt, o_pos
    );

    modport slave (
        input  i_period, i_burst, i_start, i_stop, i_step, i_resync,
        output o_valid, o_sr_reset, o_busy, o_done, o_step_cnt, o_pos
    );

endinterface

// File: rtl/shiftreg_seq_ctrl_prescaler.sv
// Period counter: one-cycle terminal-count tick every max(period,1) enabled clocks; clear wins over enable.
module shiftreg_seq_ctrl_prescaler #(
    parameter int unsigned NB_PRESCALE = 24
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic [NB_PRESCALE-1:0] i_period,
    output logic                   o_tick_c
);

    logic [NB_PRESCALE-1:0] cnt_q;
    logic [NB_PRESCALE-1:0] last_c;

    // A zero period behaves like one: tick on every enabled cycle.
    assign last_c   = (i_period == '0) ? '0 : i_period - NB_PRESCALE'(1);
    assign o_tick_c = i_enable && (cnt_q >= last_c);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_enable) begin
            cnt_q <= o_tick_c ? '0 : cnt_q + NB_PRESCALE'(1);
        end
    end

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// Sequencer for the LED rotating shift register: run/stop, single step, bursts, pattern resync, status mirror.
module shiftreg_seq_ctrl
    import shiftreg_seq_ctrl_pkg::*;
#(
    parameter int unsigned NB_LEDS     = NB_LEDS_DEF,
    parameter int unsigned NB_PRESCALE = NB_PRESCALE_DEF,
    parameter int unsigned NB_STEPS    = NB_STEPS_DEF
) (
    input  logic                 clock,
    input  logic                 i_reset,
    shiftreg_seq_ctrl_if.slave   bus
);

    localparam int unsigned       NB_POS   = clog2(NB_LEDS);
    localparam logic [NB_POS-1:0] POS_LAST = NB_POS'(NB_LEDS - 1);

    logic [ST_W-1:0]        state_q, state_d;
    logic [NB_PRESCALE-1:0] period_q;
    logic [NB_STEPS-1:0]    burst_q;
    logic [NB_STEPS-1:0]    step_cnt_q, step_cnt_d;
    logic [NB_POS-1:0]      pos_q, pos_d;
    logic                   valid_q, valid_d;
    logic                   sr_reset_q, sr_reset_d;
    logic                   done_q, done_d;
    logic                   busy_q;
    logic                   presc_clear;
    logic                   latch;
    logic                   tick_c;
    logic [NB_STEPS-1:0]    step_inc;
    logic [NB_POS-1:0]      pos_inc;
    logic                   burst_hit;

    shiftreg_seq_ctrl_prescaler #(
        .NB_PRESCALE (NB_PRESCALE)
    ) u_prescaler (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_clear  (presc_clear),
        .i_enable (state_q == ST_RUN),
        .i_period (period_q),
        .o_tick_c (tick_c)
    );

    assign step_inc  = step_cnt_q + NB_STEPS'(1);
    assign pos_inc   = (pos_q == POS_LAST) ? '0 : pos_q + NB_POS'(1);
    // A finite burst is complete once the step count has reached the latched length.
    assign burst_hit = (burst_q != '0) && (step_cnt_q >= burst_q);

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        pos_d       = pos_q;
        valid_d     = 1'b0;
        sr_reset_d  = 1'b0;
        done_d      = 1'b0;
        presc_clear = 1'b0;
        latch       = 1'b0;

        // Resync outranks every other request and leaves state and step progress alone.
        if (bus.i_resync) begin
            sr_reset_d  = 1'b1;
            pos_d       = '0;
            presc_clear = 1'b1;
            if (state_q == ST_INIT) state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_d     = ST_RUN;
                        latch       = 1'b1;
                        presc_clear = 1'b1;
                        step_cnt_d  = '0;
                    end else if (bus.i_step) begin
                        valid_d    = 1'b1;
                        step_cnt_d = NB_STEPS'(1);
                        pos_d      = pos_inc;
                    end
                end
                ST_RUN: begin
                    if (bus.i_stop || burst_hit) begin
                        state_d     = ST_IDLE;
                        presc_clear = 1'b1;
                    end else if (tick_c) begin
                        valid_d    = 1'b1;
                        step_cnt_d = step_inc;
                        pos_d      = pos_inc;
                        done_d     = (burst_q != '0) && (step_inc == burst_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_INIT;
            period_q   <= '0;
            burst_q    <= '0;
            step_cnt_q <= '0;
            pos_q      <= '0;
            valid_q    <= 1'b0;
            sr_reset_q <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            valid_q    <= valid_d;
            sr_reset_q <= sr_reset_d;
            done_q     <= done_d;
            busy_q     <= (state_d == ST_RUN);
            if (latch) begin
                period_q <= bus.i_period;
                burst_q  <= bus.i_burst;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_sr_reset = sr_reset_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_step_cnt = step_cnt_q;
    assign bus.o_pos      = pos_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Self-checking bench for shiftreg_seq_ctrl: table-driven runs plus hand sequences, strobes checked via a scoreboard.
module tb_shiftreg_seq_ctrl;
    import shiftreg_seq_ctrl_pkg::*;

    localparam int unsigned NB_LEDS     = 4;
    localparam int unsigned NB_PRESCALE = 24;
    localparam int unsigned NB_STEPS    = 8;
    localparam int unsigned NB_POS      = clog2(NB_LEDS);

    typedef struct {
        int                  cyc;
        logic [NB_STEPS-1:0] cnt;
        logic [NB_POS-1:0]   pos;
        logic                done;
    } exp_t;

    typedef struct {
        int period;
        int burst;
        int stop;
        bit with_step;
    } vec_t;

    logic clock = 1'b0;
    logic i_reset = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_pos = 0;
    exp_t sbq[$];
    vec_t vecs[7];

    shiftreg_seq_ctrl_if #(
        .NB_LEDS(NB_LEDS), .NB_PRESCALE(NB_PRESCALE), .NB_STEPS(NB_STEPS)
    ) bus ();

    shiftreg_seq_ctrl #(
        .NB_LEDS(NB_LEDS), .NB_PRESCALE(NB_PRESCALE), .NB_STEPS(NB_STEPS)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Every strobe must match the oldest pending expectation, including its cycle.
    always @(negedge clock) begin
        exp_t e;
        if (bus.o_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("valid_cnt", int'(bus.o_step_cnt), int'(e.cnt));
                check("valid_pos", int'(bus.o_pos), int'(e.pos));
                check("valid_done", int'(bus.o_done), int'(e.done));
            end
        end else if (bus.o_done) begin
            check("done_needs_valid", int'(bus.o_valid), 1);
        end
    end

    task automatic go_edge(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        go_edge(n);
        @(negedge clock);
    endtask

    task automatic push(input int t, input int k, input bit dn);
        exp_t e;
        exp_pos = (exp_pos + 1) % NB_LEDS;
        e.cyc  = t;
        e.cnt  = NB_STEPS'(k);
        e.pos  = NB_POS'(exp_pos);
        e.done = dn;
        sbq.push_back(e);
    endtask

    task automatic drain(input string nm);
        check(nm, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int e_edge, pe, n, t;
        e_edge = cyc + 1;
        bus.i_period = NB_PRESCALE'(v.period);
        bus.i_burst  = NB_STEPS'(v.burst);
        bus.i_start  = 1'b1;
        bus.i_step   = v.with_step;
        go_edge(e_edge);
        pe = (v.period == 0) ? 1 : v.period;
        n  = 0;
        for (int k = 1; k < 400; k++) begin
            t = e_edge + k * pe;
            if (v.burst != 0 && k > v.burst) break;
            if (v.stop != 0 && t >= e_edge + v.stop) break;
            n++;
            push(t, k, (v.burst != 0) && (k == v.burst));
        end
        // Mid-run start/step must be ignored and new period/burst must not take effect.
        bus.i_period = NB_PRESCALE'(7);
        bus.i_burst  = '0;
        bus.i_step   = 1'b1;
        go_edge(e_edge + 1);
        bus.i_start = 1'b0;
        bus.i_step  = 1'b0;
        if (v.stop != 0) begin
            at_neg(e_edge + v.stop - 1);
            check("busy_before_stop", int'(bus.o_busy), 1);
            bus.i_stop = 1'b1;
            go_edge(e_edge + v.stop);
            bus.i_stop = 1'b0;
            at_neg(e_edge + v.stop);
            check("busy_after_stop", int'(bus.o_busy), 0);
        end else begin
            at_neg(e_edge + v.burst * pe);
            check("busy_on_done", int'(bus.o_busy), 1);
            at_neg(e_edge + v.burst * pe + 1);
            check("busy_after_done", int'(bus.o_busy), 0);
        end
        at_neg(cyc + 2 * pe + 2);
        check("final_step_cnt", int'(bus.o_step_cnt), n % 256);
        drain("run_drained");
    endtask

    initial begin
        int r, e_edge;
        vecs[0] = '{3, 4, 0, 1'b0};
        vecs[1] = '{0, 0, 10, 1'b0};
        vecs[2] = '{4, 0, 12, 1'b0};
        vecs[3] = '{0, 3, 0, 1'b0};
        vecs[4] = '{2, 1, 0, 1'b0};
        vecs[5] = '{5, 2, 0, 1'b1};
        vecs[6] = '{1, 0, 300, 1'b0};
        bus.i_period = '0;
        bus.i_burst  = '0;
        bus.i_start  = 1'b0;
        bus.i_stop   = 1'b0;
        bus.i_step   = 1'b0;
        bus.i_resync = 1'b0;

        // Reset values, then sr_reset drops on the first edge after release.
        @(negedge clock);
        @(negedge clock);
        check("rst_sr_reset", int'(bus.o_sr_reset), 1);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_step_cnt", int'(bus.o_step_cnt), 0);
        check("rst_pos", int'(bus.o_pos), 0);
        @(posedge clock);
        #1 i_reset = 1'b1;
        r = cyc;
        at_neg(r);
        check("init_sr_reset_held", int'(bus.o_sr_reset), 1);
        at_neg(r + 1);
        check("idle_sr_reset", int'(bus.o_sr_reset), 0);
        check("idle_busy", int'(bus.o_busy), 0);
        check("idle_valid", int'(bus.o_valid), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Resync from IDLE, then three single steps.
        r = cyc + 1;
        bus.i_resync = 1'b1;
        go_edge(r);
        bus.i_resync = 1'b0;
        exp_pos = 0;
        @(negedge clock);
        check("idle_resync_sr", int'(bus.o_sr_reset), 1);
        check("idle_resync_pos", int'(bus.o_pos), 0);
        at_neg(r + 1);
        check("idle_resync_sr_drop", int'(bus.o_sr_reset), 0);
        for (int s = 0; s < 3; s++) begin
            e_edge = cyc + 1;
            push(e_edge, 1, 1'b0);
            bus.i_step = 1'b1;
            go_edge(e_edge);
            bus.i_step = 1'b0;
            go_edge(e_edge + 1);
        end
        at_neg(cyc + 1);
        check("step_pos", int'(bus.o_pos), 3);
        drain("step_drained");

        // Resync on the edge of the second strobe: strobe dropped, count kept, period restarts.
        e_edge = cyc + 1;
        bus.i_period = NB_PRESCALE'(5);
        bus.i_burst  = '0;
        bus.i_start  = 1'b1;
        push(e_edge + 5, 1, 1'b0);
        go_edge(e_edge);
        bus.i_start = 1'b0;
        exp_pos = 0;
        push(e_edge + 15, 2, 1'b0);
        push(e_edge + 20, 3, 1'b0);
        go_edge(e_edge + 9);
        bus.i_resync = 1'b1;
        go_edge(e_edge + 10);
        bus.i_resync = 1'b0;
        @(negedge clock);
        check("run_resync_sr", int'(bus.o_sr_reset), 1);
        check("run_resync_pos", int'(bus.o_pos), 0);
        check("run_resync_cnt", int'(bus.o_step_cnt), 1);
        check("run_resync_busy", int'(bus.o_busy), 1);
        go_edge(e_edge + 21);
        bus.i_stop = 1'b1;
        go_edge(e_edge + 22);
        bus.i_stop = 1'b0;
        at_neg(e_edge + 30);
        check("resync_stop_busy", int'(bus.o_busy), 0);
        drain("resync_drained");

        // Asynchronous reset in the middle of a burst.
        e_edge = cyc + 1;
        bus.i_period = NB_PRESCALE'(2);
        bus.i_burst  = NB_STEPS'(8);
        bus.i_start  = 1'b1;
        push(e_edge + 2, 1, 1'b0);
        push(e_edge + 4, 2, 1'b0);
        go_edge(e_edge);
        bus.i_start = 1'b0;
        go_edge(e_edge + 5);
        i_reset = 1'b0;
        #1;
        check("midrst_sr_reset", int'(bus.o_sr_reset), 1);
        check("midrst_busy", int'(bus.o_busy), 0);
        check("midrst_cnt", int'(bus.o_step_cnt), 0);
        check("midrst_pos", int'(bus.o_pos), 0);
        check("midrst_done", int'(bus.o_done), 0);
        drain("midrst_drained");
        go_edge(cyc + 3);
        i_reset = 1'b1;
        exp_pos = 0;
        go_edge(cyc + 1);
        check("postrst_sr_reset", int'(bus.o_sr_reset), 0);
        run_vec('{0, 2, 0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
